// File: rtl/trade_history_buffer.sv
// Circular history of executed trade prices with an indexed read port (0 = newest)
// and min/max statistics refreshed by a scan FSM after every stored trade.
module trade_history_buffer #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          match_signal,
  input  logic [DW-1:0] trade_price,
  input  logic          freeze,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic [AW:0]   count,
  output logic [DW-1:0] last_price,
  output logic [DW-1:0] min_price,
  output logic [DW-1:0] max_price,
  output logic          stats_valid,
  output logic          new_trade,
  output logic [7:0]    drop_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WRITE} state_t;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_scan_idx;
  logic          r_match_d;
  logic          r_pend;
  logic [DW-1:0] r_pend_price;
  logic [DW-1:0] r_work_min, r_work_max;

  logic          w_rise;
  logic          w_wr_en;
  logic [DW-1:0] w_wr_data;
  logic [AW-1:0] w_scan_addr;
  logic [DW-1:0] w_scan_data;
  logic          w_scan_last;
  logic [DW-1:0] w_min_nxt, w_max_nxt;
  logic [AW-1:0] w_rd_addr;
  logic          w_rd_hit;

  always_comb begin
    w_rise      = match_signal & ~r_match_d & ~freeze;
    // Ages map backwards from the write pointer; AW-bit wraparound gives modulo DEPTH.
    w_scan_addr = r_wr_ptr - AW'(1) - r_scan_idx;
    w_scan_data = r_mem[w_scan_addr];
    w_scan_last = ({1'b0, r_scan_idx} == (count - (AW+1)'(1)));
    w_min_nxt   = ((r_scan_idx == '0) || (w_scan_data < r_work_min)) ? w_scan_data : r_work_min;
    w_max_nxt   = ((r_scan_idx == '0) || (w_scan_data > r_work_max)) ? w_scan_data : r_work_max;
    w_rd_addr   = r_wr_ptr - AW'(1) - rd_idx;
    w_rd_hit    = rd_en & ({1'b0, rd_idx} < count);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_wr_data   = trade_price;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_wr_en     = 1'b1;
          w_wr_data   = trade_price;
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_scan_last) w_state_nxt = r_pend ? S_WRITE : S_IDLE;
      end
      S_WRITE: begin
        w_wr_en     = 1'b1;
        w_wr_data   = r_pend_price;
        w_state_nxt = S_SCAN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_match_d    <= 1'b0;
      r_wr_ptr     <= '0;
      r_scan_idx   <= '0;
      r_pend       <= 1'b0;
      r_pend_price <= '0;
      r_work_min   <= '0;
      r_work_max   <= '0;
      count        <= '0;
      last_price   <= '0;
      min_price    <= '0;
      max_price    <= '0;
      stats_valid  <= 1'b0;
      new_trade    <= 1'b0;
      drop_cnt     <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_match_d <= match_signal;
      new_trade <= w_wr_en;
      rd_valid  <= w_rd_hit;
      rd_data   <= w_rd_hit ? r_mem[w_rd_addr] : '0;

      if (w_wr_en) begin
        r_wr_ptr    <= r_wr_ptr + AW'(1);
        last_price  <= w_wr_data;
        stats_valid <= 1'b0;
        r_scan_idx  <= '0;
        if (count != (AW+1)'(DEPTH)) count <= count + (AW+1)'(1);
      end

      if (r_state == S_SCAN) begin
        r_scan_idx <= r_scan_idx + AW'(1);
        r_work_min <= w_min_nxt;
        r_work_max <= w_max_nxt;
        if (w_scan_last) begin
          min_price   <= w_min_nxt;
          max_price   <= w_max_nxt;
          stats_valid <= 1'b1;
        end
      end

      // A rise while the pending slot drains in WRITE refills it rather than dropping.
      if (r_state == S_WRITE) begin
        r_pend <= w_rise;
        if (w_rise) r_pend_price <= trade_price;
      end else if ((r_state == S_SCAN) && w_rise) begin
        if (!r_pend) begin
          r_pend       <= 1'b1;
          r_pend_price <= trade_price;
        end else if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_trade_history_buffer.sv
// Directed bench for trade_history_buffer with hand-computed expectations.
module tb_trade_history_buffer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       match_signal;
  logic [7:0] trade_price;
  logic       freeze;
  logic       rd_en;
  logic [5:0] rd_idx;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [6:0] count;
  logic [7:0] last_price, min_price, max_price;
  logic       stats_valid, new_trade;
  logic [7:0] drop_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  trade_history_buffer #(.DEPTH(64), .AW(6), .DW(8)) dut (
    .clk(clk), .reset_n(reset_n), .match_signal(match_signal), .trade_price(trade_price),
    .freeze(freeze), .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .last_price(last_price), .min_price(min_price), .max_price(max_price),
    .stats_valid(stats_valid), .new_trade(new_trade), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; match_signal = 1'b0; trade_price = '0;
    freeze = 1'b0; rd_en = 1'b0; rd_idx = '0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic trade(input logic [7:0] p);
    match_signal = 1'b1; trade_price = p;
    tick();
    match_signal = 1'b0;
    tick();
  endtask

  task automatic wait_stats(input string tag);
    int unsigned n = 0;
    while (!stats_valid && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic rd(input logic [5:0] idx, input logic [7:0] exp_d, input logic exp_v,
                    input string tag);
    rd_en = 1'b1; rd_idx = idx;
    tick();
    rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(rd_valid), 32'(exp_v));
    chk({tag, "_data"}, 32'(rd_data), 32'(exp_d));
  endtask

  initial begin
    do_reset();
    chk("rst_count", 32'(count), 0);
    chk("rst_stats", 32'(stats_valid), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_last", 32'(last_price), 0);

    // 1: single trade
    match_signal = 1'b1; trade_price = 8'h40;
    tick();
    match_signal = 1'b0;
    chk("t1_count", 32'(count), 1);
    chk("t1_last", 32'(last_price), 32'h40);
    chk("t1_newtrade", 32'(new_trade), 1);
    chk("t1_stats_lo", 32'(stats_valid), 0);
    tick();
    chk("t1_newtrade_off", 32'(new_trade), 0);
    chk("t1_stats", 32'(stats_valid), 1);
    chk("t1_min", 32'(min_price), 32'h40);
    chk("t1_max", 32'(max_price), 32'h40);

    // 2: three spaced trades and reads
    do_reset();
    trade(8'd10); repeat (98) tick();
    trade(8'd30); repeat (98) tick();
    trade(8'd20); repeat (98) tick();
    rd(6'd0, 8'd20, 1'b1, "t2_r0");
    rd(6'd1, 8'd30, 1'b1, "t2_r1");
    rd(6'd2, 8'd10, 1'b1, "t2_r2");
    rd(6'd3, 8'd0, 1'b0, "t2_r3");
    chk("t2_min", 32'(min_price), 10);
    chk("t2_max", 32'(max_price), 30);

    // 3: overfill by two
    do_reset();
    for (int i = 1; i <= 66; i++) begin
      trade(8'(i));
      wait_stats("t3");
    end
    chk("t3_count", 32'(count), 64);
    rd(6'd63, 8'd3, 1'b1, "t3_r63");
    rd(6'd0, 8'd66, 1'b1, "t3_r0");
    chk("t3_min", 32'(min_price), 3);
    chk("t3_max", 32'(max_price), 66);
    chk("t3_drop", 32'(drop_cnt), 0);

    // 4: pending and overflow
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      trade(8'(i));
      wait_stats("t4");
    end
    chk("t4_count10", 32'(count), 10);
    for (int k = 0; k < 3; k++) begin
      match_signal = 1'b1; trade_price = 8'(100 + k);
      tick();
      match_signal = 1'b0;
      tick(); tick();
    end
    chk("t4_drop", 32'(drop_cnt), 1);
    repeat (40) tick();
    chk("t4_count", 32'(count), 12);
    chk("t4_last", 32'(last_price), 101);
    chk("t4_max", 32'(max_price), 101);
    chk("t4_min", 32'(min_price), 1);
    chk("t4_stats", 32'(stats_valid), 1);
    rd(6'd1, 8'd100, 1'b1, "t4_r1");

    // 5: held level and freeze
    do_reset();
    match_signal = 1'b1; trade_price = 8'h55;
    repeat (20) tick();
    match_signal = 1'b0;
    repeat (5) tick();
    chk("t5_count", 32'(count), 1);
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) trade(8'h66);
    repeat (5) tick();
    freeze = 1'b0;
    chk("t5_freeze_count", 32'(count), 1);
    chk("t5_freeze_drop", 32'(drop_cnt), 0);
    chk("t5_last", 32'(last_price), 32'h55);

    // 6: async reset mid-scan
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      trade(8'(i + 20));
      wait_stats("t6");
    end
    trade(8'h90);
    chk("t6_scanning", 32'(stats_valid), 0);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_last", 32'(last_price), 0);
    chk("t6_rst_max", 32'(max_price), 0);
    chk("t6_rst_stats", 32'(stats_valid), 0);
    tick();
    reset_n = 1'b1;
    tick();
    trade(8'h77);
    wait_stats("t6b");
    chk("t6_count", 32'(count), 1);
    chk("t6_min", 32'(min_price), 32'h77);
    chk("t6_max", 32'(max_price), 32'h77);
    rd(6'd0, 8'h77, 1'b1, "t6_r0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
